// File: rtl/bitplane_accumulator_if.sv
// ---------------------------------------------------------------------------
// bitplane_accumulator_if
//   Groups the input word stream, the flush handshake and the result
//   valid/ready handshake of bitplane_accumulator.
//   master : producer/consumer side (drives enable, numin, flush, out_ready)
//   slave  : accumulator side (drives flush_ready, out_valid, countout, out_ovf)
// Parameters:
//   size_input - input word width
//   size_out   - result width (signed two's complement)
// ---------------------------------------------------------------------------
interface bitplane_accumulator_if #(
    parameter int size_input = 8,
    parameter int size_out   = 12
);
    logic                  enable;
    logic [size_input-1:0] numin;
    logic                  flush;
    logic                  flush_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [size_out-1:0]   countout;
    logic                  out_ovf;

    modport master (
        output enable, numin, flush, out_ready,
        input  flush_ready, out_valid, countout, out_ovf
    );

    modport slave (
        input  enable, numin, flush, out_ready,
        output flush_ready, out_valid, countout, out_ovf
    );
endinterface

// File: rtl/bitplane_accumulator.sv
// ---------------------------------------------------------------------------
// bitplane_accumulator
//   Counts the ones seen at each bit position of a word stream in saturating
//   per-bit counters. A flush snapshots the counts (including the word of the
//   flush cycle) and reduces them MSB-first with a shift-add into the weighted
//   sum, delivered on a valid/ready result port. Counting of the next batch
//   continues while the reduction runs.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous reset, active low
//   bus    - bitplane_accumulator_if.slave (enable/numin, flush/flush_ready,
//            out_valid/out_ready, countout, out_ovf)
//
// Build option:
//   COMP_SIGNED_EN - when defined, the MSB position counter is weighted
//                    negatively (two's-complement input words).
// ---------------------------------------------------------------------------

// One saturating ones-counter for a single bit position.
module bitplane_counter #(
    parameter int size_code = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 bit_in,
    input  logic                 clear,
    output logic [size_code-1:0] cnt_nxt,  // count including this cycle's bit
    output logic                 sat_hit   // increment attempted while full
);
    localparam logic [size_code-1:0] CMAX = '1;

    logic [size_code-1:0] cnt;

    always_comb begin
        cnt_nxt = cnt;
        sat_hit = 1'b0;
        if (enable && bit_in) begin
            if (cnt == CMAX) sat_hit = 1'b1;
            else             cnt_nxt = cnt + 1'b1;
        end
    end

    // A clear (flush accepted) wins: that cycle's bit goes into the snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cnt <= '0;
        else if (clear) cnt <= '0;
        else            cnt <= cnt_nxt;
    end
endmodule

module bitplane_accumulator #(
    parameter int size_input = 8,
    parameter int size_code  = 3,
    parameter int size_out   = size_input + size_code + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    bitplane_accumulator_if.slave   bus
);
    localparam int KW = $clog2(size_input);

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t state, state_nxt;

    logic [size_input-1:0][size_code-1:0] cnt_nxt;
    logic [size_input-1:0][size_code-1:0] snap;
    logic [size_input-1:0]                sat_hit;
    logic                                 ovf_sticky, ovf_nxt, snap_ovf;
    logic [KW-1:0]                        k;
    logic [size_out-1:0]                  acc, acc_step, w;
    logic                                 accept, last_step;

    // ---------------- per-bit counters ----------------
    for (genvar i = 0; i < size_input; i++) begin : g_cnt
        bitplane_counter #(.size_code(size_code)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .enable  (bus.enable),
            .bit_in  (bus.numin[i]),
            .clear   (accept),
            .cnt_nxt (cnt_nxt[i]),
            .sat_hit (sat_hit[i])
        );
    end

    assign accept          = bus.flush && (state == IDLE);
    assign last_step       = (state == REDUCE) && (k == '0);
    assign ovf_nxt         = ovf_sticky | (|sat_hit);
    assign bus.flush_ready = (state == IDLE);

    // ---------------- reduction step (Horner, MSB first) ----------------
    always_comb begin
        w = {{(size_out-size_code){1'b0}}, snap[k]};
`ifdef COMP_SIGNED_EN
        // Sign-bit position carries weight -2^(size_input-1).
        if (k == KW'(size_input-1)) w = -w;
`endif
        acc_step = {acc[size_out-2:0], 1'b0} + w;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                       state_nxt = REDUCE;
            REDUCE:  if (last_step)                    state_nxt = DONE;
            DONE:    if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sticky    <= 1'b0;
            snap          <= '0;
            snap_ovf      <= 1'b0;
            k             <= '0;
            acc           <= '0;
            bus.countout  <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            ovf_sticky <= accept ? 1'b0 : ovf_nxt;

            if (accept) begin
                snap     <= cnt_nxt;
                snap_ovf <= ovf_nxt;
                k        <= KW'(size_input-1);
                acc      <= '0;
            end else if (state == REDUCE) begin
                acc <= acc_step;
                k   <= k - 1'b1;
            end

            if (last_step) begin
                bus.countout  <= acc_step;
                bus.out_ovf   <= snap_ovf;
                bus.out_valid <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitplane_accumulator.sv
// ---------------------------------------------------------------------------
// tb_bitplane_accumulator
//   Scoreboard bench: a bit-position count model pushes the expected
//   {countout, out_ovf} when a flush is accepted; results are popped and
//   compared when the DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_bitplane_accumulator;
    localparam int SI = 8;
    localparam int SC = 3;
    localparam int SO = SI + SC + 1;
    localparam int CMAX = (1 << SC) - 1;

    typedef struct {
        logic [SO-1:0] val;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitplane_accumulator_if #(.size_input(SI), .size_out(SO)) bus ();

    bitplane_accumulator #(.size_input(SI), .size_code(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   mcnt[SI];
    logic movf;

    function automatic exp_t model_result();
        int   s;
        exp_t e;
        logic [31:0] s32;
        s = 0;
        for (int i = 0; i < SI - 1; i++) s += mcnt[i] * (1 << i);
`ifdef COMP_SIGNED_EN
        s -= mcnt[SI-1] * (1 << (SI - 1));
`else
        s += mcnt[SI-1] * (1 << (SI - 1));
`endif
        s32   = s;
        e.val = s32[SO-1:0];
        e.ovf = movf;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SI; i++) mcnt[i] = 0;
        movf = 1'b0;
    endtask

    // One clock with the given inputs; model follows the same edge.
    task automatic step(input logic en, input logic [SI-1:0] num, input logic fl);
        logic fr;
        bus.enable = en;
        bus.numin  = num;
        bus.flush  = fl;
        fr = bus.flush_ready;
        @(posedge clk);
        if (en)
            for (int i = 0; i < SI; i++)
                if (num[i]) begin
                    if (mcnt[i] == CMAX) movf = 1'b1;
                    else                 mcnt[i]++;
                end
        if (fl && fr) begin
            sb.push_back(model_result());
            model_clear();
        end
        #1;
        bus.enable = 1'b0;
        bus.numin  = '0;
        bus.flush  = 1'b0;
    endtask

    // Wait (bounded) for a result, compare against the scoreboard, handshake.
    task automatic collect(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!bus.out_valid) begin
            failures++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, bus.out_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected result: queue size=0 required >0", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.countout !== e.val) begin
            failures++;
            $display("FAIL %s countout: got %h required %h", name, bus.countout, e.val);
        end
        checks++;
        if (bus.out_ovf !== e.ovf) begin
            failures++;
            $display("FAIL %s out_ovf: got %b required %b", name, bus.out_ovf, e.ovf);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.flush_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: out_valid=%b flush_ready=%b required 0/1",
                     name, bus.out_valid, bus.flush_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.enable = 1'b0; bus.numin = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.flush_ready !== 1'b1 ||
            bus.countout !== '0 || bus.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b fr=%b count=%h ovf=%b required 0/1/0/0",
                     bus.out_valid, bus.flush_ready, bus.countout, bus.out_ovf);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        repeat (3) step(1'b1, 8'h01, 1'b0);
        step(1'b0, '0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            checks++;
            if (bus.flush_ready !== 1'b0) begin
                failures++;
                $display("FAIL basic flush_ready busy: got %b required 0", bus.flush_ready);
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != SI) begin
            failures++;
            $display("FAIL basic latency: got %0d edges required %0d", n, SI);
        end
        checks++;
        if (bus.countout !== SO'(3)) begin
            failures++;
            $display("FAIL basic countout const: got %h required %h", bus.countout, SO'(3));
        end
        collect("basic");
    endtask

    task automatic test_msb();
        logic [SO-1:0] req;
`ifdef COMP_SIGNED_EN
        req = 12'hF00;  // -256
`else
        req = 12'h100;  // 256
`endif
        repeat (2) step(1'b1, 8'h80, 1'b0);
        step(1'b0, '0, 1'b1);
        repeat (SI) @(posedge clk);
        #1;
        checks++;
        if (bus.countout !== req) begin
            failures++;
            $display("FAIL msb countout const: got %h required %h", bus.countout, req);
        end
        collect("msb");
    endtask

    task automatic test_saturation();
        logic [SO-1:0] req;
`ifdef COMP_SIGNED_EN
        req = 12'hFF9;  // -7
`else
        req = 12'd1785;
`endif
        repeat (9) step(1'b1, 8'hFF, 1'b0);
        step(1'b0, '0, 1'b1);
        repeat (SI) @(posedge clk);
        #1;
        checks++;
        if (bus.countout !== req || bus.out_ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat const: got %h/%b required %h/1", bus.countout, bus.out_ovf, req);
        end
        collect("saturation");
    endtask

    task automatic test_overlap();
        step(1'b0, '0, 1'b1);            // empty batch, result 0
        checks++;
        if (bus.flush_ready !== 1'b0) begin
            failures++;
            $display("FAIL overlap flush_ready: got %b required 0", bus.flush_ready);
        end
        step(1'b1, 8'h02, 1'b1);         // flush ignored
        step(1'b1, 8'h02, 1'b0);
        collect("overlap_first");
        step(1'b0, '0, 1'b1);
        collect("overlap_second");       // model expects 4
    endtask

    task automatic test_backpressure();
        logic [SO-1:0] c;
        logic          o;
        step(1'b1, 8'h35, 1'b0);
        step(1'b1, 8'h0F, 1'b1);
        repeat (SI) @(posedge clk);
        #1;
        c = bus.countout;
        o = bus.out_ovf;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.countout !== c || bus.out_ovf !== o ||
                bus.flush_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure hold %0d: valid=%b count=%h fr=%b required 1/%h/0",
                         i, bus.out_valid, bus.countout, bus.flush_ready, c);
            end
            @(posedge clk); #1;
        end
        collect("backpressure");
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, '0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.flush_ready !== 1'b1 || bus.countout !== '0) begin
            failures++;
            $display("FAIL reset_mid async: valid=%b fr=%b count=%h required 0/1/0",
                     bus.out_valid, bus.flush_ready, bus.countout);
        end
        sb.delete();
        model_clear();
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        step(1'b0, '0, 1'b1);
        collect("reset_mid_after");
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL reset_mid queue: got %0d required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 8; b++) begin
            int len;
            len = $urandom_range(0, 12);
            for (int j = 0; j < len; j++)
                step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            for (int j = 0; j < 4; j++)
                step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            collect("back_to_back");
        end
        step(1'b0, '0, 1'b1);
        collect("back_to_back_tail");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_msb();
        test_saturation();
        test_overlap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
